// File: rtl/datapath_dst_demux15.sv
// Five-way packet demultiplexer: the first beat's destination code steers the whole packet
// through a single registered output stage; illegal codes discard the packet and are counted.
module datapath_dst_demux15 #(
  parameter int DWID   = 24,
  parameter int CH_NUM = 8,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     S,
  input  logic                           Z_valid,
  output logic                           Z_ready,
  input  logic [CH_NUM-1:0][DWID-1:0]    Z_data,
  input  logic                           Z_last,
  output logic                           A_valid,
  output logic                           B_valid,
  output logic                           C_valid,
  output logic                           D_valid,
  output logic                           E_valid,
  input  logic                           A_ready,
  input  logic                           B_ready,
  input  logic                           C_ready,
  input  logic                           D_ready,
  input  logic                           E_ready,
  output logic [CH_NUM-1:0][DWID-1:0]    A_data,
  output logic [CH_NUM-1:0][DWID-1:0]    B_data,
  output logic [CH_NUM-1:0][DWID-1:0]    C_data,
  output logic [CH_NUM-1:0][DWID-1:0]    D_data,
  output logic [CH_NUM-1:0][DWID-1:0]    E_data,
  output logic                           A_last,
  output logic                           B_last,
  output logic                           C_last,
  output logic                           D_last,
  output logic                           E_last,
  output logic [CNT_W-1:0]               pkt_cnt,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic                           err
);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                         state;
  logic [2:0]                     sel_q;
  logic                           vld_p1;
  logic [CH_NUM-1:0][DWID-1:0]    data_p1;
  logic                           last_p1;
  logic [2:0]                     dest_p1;

  logic       illegal, start_drop, dest_ready, load_ok, accept, fwd, take;
  logic [2:0] route_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    illegal    = (S > 3'd4);
    start_drop = (state == IDLE) && illegal;
    route_sel  = (state == ROUTE) ? sel_q : S;
    case (dest_p1)
      3'd0:    dest_ready = A_ready;
      3'd1:    dest_ready = B_ready;
      3'd2:    dest_ready = C_ready;
      3'd3:    dest_ready = D_ready;
      3'd4:    dest_ready = E_ready;
      default: dest_ready = 1'b0;
    endcase
    load_ok = !vld_p1 || dest_ready;
    // Discarded beats never touch the output stage, so they are always accepted.
    if (rst)
      Z_ready = 1'b0;
    else if ((state == DROP) || start_drop)
      Z_ready = 1'b1;
    else
      Z_ready = load_ok;
    accept = Z_valid && Z_ready;
    fwd    = accept && (state != DROP) && !start_drop;
    take   = vld_p1 && dest_ready;
  end

  // Stage p1: route FSM, shared output register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 3'd0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      last_p1  <= 1'b0;
      dest_p1  <= 3'd0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Z_valid && !illegal)
            sel_q <= S;
          if (accept) begin
            if (illegal) begin
              err      <= 1'b1;
              drop_cnt <= sat_inc(drop_cnt);
              if (!Z_last) state <= DROP;
            end else if (!Z_last) begin
              state <= ROUTE;
            end
          end
        end
        ROUTE, DROP: if (accept && Z_last) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fwd) begin
        vld_p1  <= 1'b1;
        data_p1 <= Z_data;
        last_p1 <= Z_last;
        dest_p1 <= route_sel;
      end else if (take) begin
        vld_p1 <= 1'b0;
      end

      if (take && last_p1)
        pkt_cnt <= sat_inc(pkt_cnt);
    end
  end

  assign A_valid = vld_p1 && (dest_p1 == 3'd0);
  assign B_valid = vld_p1 && (dest_p1 == 3'd1);
  assign C_valid = vld_p1 && (dest_p1 == 3'd2);
  assign D_valid = vld_p1 && (dest_p1 == 3'd3);
  assign E_valid = vld_p1 && (dest_p1 == 3'd4);

  assign A_data = data_p1;
  assign B_data = data_p1;
  assign C_data = data_p1;
  assign D_data = data_p1;
  assign E_data = data_p1;

  assign A_last = last_p1;
  assign B_last = last_p1;
  assign C_last = last_p1;
  assign D_last = last_p1;
  assign E_last = last_p1;

endmodule

// File: tb/tb_datapath_dst_demux15.sv
// Directed bench for datapath_dst_demux15: routing, backpressure, drops and reset.
module tb_datapath_dst_demux15;
  localparam int DWID = 24, CH_NUM = 8, CNT_W = 16, DW = DWID * CH_NUM;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    S;
  logic          Z_valid, Z_ready, Z_last;
  logic [DW-1:0] Z_data;
  logic          A_valid, B_valid, C_valid, D_valid, E_valid;
  logic          A_ready, B_ready, C_ready, D_ready, E_ready;
  logic [DW-1:0] A_data, B_data, C_data, D_data, E_data;
  logic          A_last, B_last, C_last, D_last, E_last;
  logic [CNT_W-1:0] pkt_cnt, drop_cnt;
  logic          err;
  logic [4:0]    vv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  datapath_dst_demux15 #(.DWID(DWID), .CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .S(S),
    .Z_valid(Z_valid), .Z_ready(Z_ready), .Z_data(Z_data), .Z_last(Z_last),
    .A_valid(A_valid), .B_valid(B_valid), .C_valid(C_valid), .D_valid(D_valid), .E_valid(E_valid),
    .A_ready(A_ready), .B_ready(B_ready), .C_ready(C_ready), .D_ready(D_ready), .E_ready(E_ready),
    .A_data(A_data), .B_data(B_data), .C_data(C_data), .D_data(D_data), .E_data(E_data),
    .A_last(A_last), .B_last(B_last), .C_last(C_last), .D_last(D_last), .E_last(E_last),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err(err)
  );

  assign vv = {E_valid, D_valid, C_valid, B_valid, A_valid};

  function automatic logic [DW-1:0] word(input int k);
    logic [DW-1:0] r;
    for (int i = 0; i < CH_NUM; i++) r[i*DWID +: DWID] = DWID'(k * 16 + i + 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; S = 3'd0; Z_valid = 1'b0; Z_last = 1'b0; Z_data = '0;
    {A_ready, B_ready, C_ready, D_ready, E_ready} = 5'b11111;

    // Reset state
    cyc(); cyc();
    chk("rst_zready", Z_ready, 0);
    chk("rst_valid", vv, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_data", A_data, 0);
    rst = 1'b0;
    cyc();

    // Single-beat packet to C
    S = 3'd2; Z_valid = 1'b1; Z_data = word(1); Z_last = 1'b1;
    #1 chk("c_zready", Z_ready, 1);
    cyc();
    Z_valid = 1'b0;
    chk("c_valid", vv, 5'b00100);
    chk("c_data", C_data, word(1));
    chk("c_last", C_last, 1);
    cyc();
    chk("c_drain", vv, 0);
    chk("c_pkt", pkt_cnt, 1);

    // Four-beat packet to B; S changes to E after the first beat
    for (int k = 0; k < 4; k++) begin
      S = (k == 0) ? 3'd1 : 3'd4;
      Z_valid = 1'b1; Z_data = word(10 + k); Z_last = (k == 3);
      #1 chk("b_zready", Z_ready, 1);
      cyc();
      chk("b_valid", vv, 5'b00010);
      chk("b_data", B_data, word(10 + k));
      chk("b_last", B_last, (k == 3));
    end
    Z_valid = 1'b0;
    cyc();
    chk("b_drain", vv, 0);
    chk("b_pkt", pkt_cnt, 2);

    // Backpressure on D: two-beat packet, D_ready low for three edges
    D_ready = 1'b0;
    S = 3'd3; Z_valid = 1'b1; Z_data = word(20); Z_last = 1'b0;
    #1 chk("d_zready0", Z_ready, 1);
    cyc();
    Z_data = word(21); Z_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("d_stall_zready", Z_ready, 0);
      chk("d_stall_valid", vv, 5'b01000);
      chk("d_stall_data", D_data, word(20));
      chk("d_stall_last", D_last, 0);
      if (k < 2) cyc();
    end
    D_ready = 1'b1;
    #1 chk("d_release_zready", Z_ready, 1);
    cyc();
    Z_valid = 1'b0;
    chk("d_b1_valid", vv, 5'b01000);
    chk("d_b1_data", D_data, word(21));
    chk("d_b1_last", D_last, 1);
    chk("d_pkt_mid", pkt_cnt, 2);
    cyc();
    chk("d_drain", vv, 0);
    chk("d_pkt", pkt_cnt, 3);

    // Illegal code: three beats dropped, then a legal packet to A
    for (int k = 0; k < 3; k++) begin
      S = 3'd6; Z_valid = 1'b1; Z_data = word(30 + k); Z_last = (k == 2);
      #1 chk("drop_zready", Z_ready, 1);
      cyc();
      chk("drop_valid", vv, 0);
      chk("drop_cnt", drop_cnt, 1);
      chk("drop_err", err, 1);
    end
    S = 3'd0; Z_valid = 1'b1; Z_data = word(40); Z_last = 1'b1;
    cyc();
    Z_valid = 1'b0;
    chk("a_valid", vv, 5'b00001);
    chk("a_data", A_data, word(40));
    cyc();
    chk("a_pkt", pkt_cnt, 4);
    chk("a_err_sticky", err, 1);

    // Back-to-back two-beat packets to A then E, no bubble
    for (int k = 0; k < 4; k++) begin
      S = (k < 2) ? 3'd0 : 3'd4;
      Z_valid = 1'b1; Z_data = word(50 + k); Z_last = (k % 2 == 1);
      #1 chk("bb_zready", Z_ready, 1);
      cyc();
      chk("bb_valid", vv, (k < 2) ? 5'b00001 : 5'b10000);
      chk("bb_data", A_data, word(50 + k));
    end
    Z_valid = 1'b0;
    cyc();
    chk("bb_pkt", pkt_cnt, 6);
    chk("bb_drop", drop_cnt, 1);

    // Reset in the middle of a four-beat packet to B
    for (int k = 0; k < 2; k++) begin
      S = 3'd1; Z_valid = 1'b1; Z_data = word(60 + k); Z_last = 1'b0;
      cyc();
    end
    chk("mid_valid", vv, 5'b00010);
    rst = 1'b1; Z_data = word(62);
    #1 chk("mid_rst_zready", Z_ready, 0);
    cyc();
    chk("mid_rst_valid", vv, 0);
    chk("mid_rst_pkt", pkt_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_err", err, 0);
    rst = 1'b0; Z_valid = 1'b0;
    cyc();
    S = 3'd3; Z_valid = 1'b1; Z_data = word(70); Z_last = 1'b1;
    cyc();
    Z_valid = 1'b0;
    chk("post_rst_valid", vv, 5'b01000);
    chk("post_rst_data", D_data, word(70));
    cyc();
    chk("post_rst_pkt", pkt_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/datapath_dst_demux15.md
DATAPATH_DST_DEMUX15 -- requirements
Module: datapath_dst_demux15

Parameters
REQ-001 DWID, default 24, bits per channel word.
REQ-002 CH_NUM, default 8, channels per beat.
REQ-003 CNT_W, default 16, width of the packet and drop counters.

Interface
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset: synchronous and active-high.
REQ-006 S  input  3  destination code, sampled only on the first beat of a packet: 000 A, 001 B, 010 C, 011 D, 100 E, 101-111 illegal.
REQ-007 Z_valid  input  1  upstream beat valid.
REQ-008 Z_ready  output  1  upstream beat accept.
REQ-009 Z_data  input  CH_NUM*DWID  upstream beat, packed [CH_NUM-1:0][DWID-1:0].
REQ-010 Z_last  input  1  final beat of the packet.
REQ-011 A_valid..E_valid  output  1 each  per-destination beat valid.
REQ-012 A_ready..E_ready  input  1 each  per-destination accept.
REQ-013 A_data..E_data  output  CH_NUM*DWID each  per-destination beat; all five carry the same registered word.
REQ-014 A_last..E_last  output  1 each  per-destination last flag; all five carry the same registered flag.
REQ-015 pkt_cnt  output  CNT_W  packets fully forwarded (last beat accepted downstream).
REQ-016 drop_cnt  output  CNT_W  packets discarded because of an illegal code.
REQ-017 err  output  1  sticky flag, set by any illegal-code packet.

Function
REQ-018 The route FSM SHALL have three states: IDLE, ROUTE, DROP.
- IDLE: no packet in progress.
- ROUTE: forwarding a packet to sel_q.
- DROP: discarding a packet.
REQ-019 IDLE, Z_valid=1, legal S:
- The beat is routed with S directly; no bubble.
- S SHALL be latched into sel_q.
- If the beat is accepted and Z_last=0, the FSM SHALL go to ROUTE.
- If the beat is accepted and Z_last=1, the FSM SHALL stay in IDLE.
REQ-020 ROUTE: every beat SHALL go to sel_q and S SHALL be ignored; an accepted beat with Z_last=1 SHALL return the FSM to IDLE.
REQ-021 IDLE, Z_valid=1, illegal S:
- Z_ready SHALL be 1 and the beat is discarded.
- err SHALL be set and drop_cnt SHALL increment once.
- The FSM SHALL go to DROP, unless Z_last=1, in which case it stays in IDLE.
REQ-022 DROP: Z_ready SHALL be 1 and all beats discarded; a beat with Z_last=1 SHALL return the FSM to IDLE.
REQ-023 Output stage: one shared register holding out_valid, data, last and dest.
- Exactly one X_valid SHALL be high, namely the one whose code equals dest, and only when out_valid=1.
- X_valid SHALL be low for every other destination.
REQ-024 In IDLE/ROUTE, Z_ready SHALL equal (!out_valid || ready of dest) and is combinational from the downstream ready; the stage sustains one beat per cycle.
REQ-025 Latency: a beat accepted in cycle N SHALL be visible on the outputs in cycle N+1.
REQ-026 A simultaneous accept of a new beat and downstream take of the old one in the same cycle SHALL reload the register with no bubble.
REQ-027 While out_valid=1 and the downstream ready is 0, the data, last and dest registers SHALL hold stable.
REQ-028 Upstream rule: Z_data, Z_last and S SHALL be held while Z_valid=1 and Z_ready=0; the block does not check this.
REQ-029 pkt_cnt SHALL increment when a last beat leaves the output stage.
REQ-030 Both counters SHALL saturate at all-ones.
REQ-031 The ready inputs of non-selected destinations SHALL have no effect.

Reset
REQ-032 While rst=1 the block SHALL force the state below at the next clock edge:
- FSM=IDLE, sel_q=000, out_valid=0, all X_valid=0;
- data/last registers=0;
- pkt_cnt=0, drop_cnt=0, err=0.
REQ-033 Z_ready SHALL be 0 during reset cycles.
REQ-034 A reset mid-packet SHALL abandon the packet; the beat held in the output stage is lost.
REQ-035 After reset the first valid beat SHALL be treated as a packet start.

Verification
REQ-036 Single-beat packet S=010, Z_last=1, C_ready=1 -> C_valid=1 one cycle later with the data and C_last=1; A/B/D/E_valid=0; pkt_cnt=1.
REQ-037 Four-beat packet S=001, S changed to 100 after beat 1, B_ready=1 -> all 4 beats reach B in 4 consecutive cycles; E_valid never 1; pkt_cnt=1.
REQ-038 Backpressure on destination D:
- Stimulus: S=011, D_ready=0 for 3 cycles, then 1.
- Response: Z_ready=0 while out_valid=1; D_data stable; no beat lost or duplicated.
REQ-039 Three-beat packet with S=110 -> Z_ready=1 on all 3 beats; no X_valid ever asserted; drop_cnt=1; err=1. Next packet with S=000 -> reaches A normally.
REQ-040 Two back-to-back 2-beat packets (S=000 then S=100), all ready=1 -> 4 beats in 4 cycles with no bubble at the boundary; pkt_cnt=2.
REQ-041 rst=1 asserted in the middle of a 4-beat packet -> next cycle all X_valid=0, counters=0, err=0; the following packet with S=011 goes to D.
